// File: rtl/fifo_nibble_tx_pkg.sv
// Shared types and constants for the nibble FIFO serial drain.
// FIFO_TX_PARITY_EN adds an even-parity bit after the data bits.
package fifo_tx_pkg;

  localparam int unsigned DBITS_DEF  = 4;
  localparam int unsigned BIT_IDX_W  = $clog2(DBITS_DEF + 1);
  localparam int unsigned BAUD_CNT_W = $clog2(256);

`ifdef FIFO_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  localparam int unsigned PARITY_BITS = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

  // Serial bits in one frame: start + data + optional parity + stop.
  function automatic int unsigned bits_per_frame(input int unsigned dbits);
    return dbits + 2 + PARITY_BITS;
  endfunction

  function automatic int unsigned frame_cycles(input int unsigned dbits,
                                               input int unsigned clks_per_bit);
    return bits_per_frame(dbits) * clks_per_bit;
  endfunction

  function automatic int unsigned bit_idx_w(input int unsigned dbits);
    return $clog2(dbits + 1);
  endfunction

endpackage

// File: rtl/fifo_nibble_tx_if.sv
// Read-side handshake between the nibble FIFO and its serial drain.
interface fifo_nibble_tx_if #(
  parameter int unsigned DBITS = 4
);
  logic             fifo_empty;
  logic [DBITS-1:0] fifo_dout;
  logic             fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd
  );
endinterface

// File: rtl/fifo_nibble_tx_baud_tick_gen.sv
// Bit-period timer: cleared by load, pulses bit_done_c on the last cycle of each bit.
module baud_tick_gen
  import fifo_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic bit_done_c
);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic                  last_c;

  assign last_c     = (cnt_q == BAUD_CNT_W'(CLKS_PER_BIT - 1));
  assign bit_done_c = run && !load && last_c;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= last_c ? '0 : cnt_q + BAUD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_nibble_tx.sv
// Pops nibble FIFO entries and sends each as a start/data(LSB first)/stop serial frame.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_nibble_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DBITS        = DBITS_DEF,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  fifo_nibble_tx_if.master    fifo,
  output logic                tx,
  output logic                busy,
  output logic [CNT_W-1:0]    frames_sent
);

  localparam int unsigned IDX_W = bit_idx_w(DBITS);

  tx_state_e          state_q, state_d;
  logic [DBITS-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               tx_d, busy_d, rd_d;
  logic               load_c, run_c, bit_done_c;
`ifdef FIFO_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .run        (run_c),
    .bit_done_c (bit_done_c)
  );

  // Next state, datapath updates, and registered-output targets.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = frames_sent;
    load_c  = 1'b0;
    run_c   = 1'b0;
`ifdef FIFO_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo.fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        load_c  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        load_c  = 1'b1;
        shift_d = fifo.fifo_dout;
        idx_d   = '0;
`ifdef FIFO_TX_PARITY_EN
        parity_d = ^fifo.fifo_dout;
`endif
        state_d = ST_START;
      end
      ST_START: begin
        run_c = 1'b1;
        if (bit_done_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        run_c = 1'b1;
        if (bit_done_c) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DBITS - 1)) begin
`ifdef FIFO_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: begin
        run_c = 1'b1;
        if (bit_done_c) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        run_c = 1'b1;
        if (bit_done_c) begin
          cnt_d   = frames_sent + CNT_W'(1);
          state_d = (enable && !fifo.fifo_empty) ? ST_POP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the upcoming state so they align with it.
    rd_d   = (state_d == ST_POP);
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      frames_sent  <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      fifo.fifo_rd <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      frames_sent  <= cnt_d;
      tx           <= tx_d;
      busy         <= busy_d;
      fifo.fifo_rd <= rd_d;
`ifdef FIFO_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Randomized bench for fifo_nibble_tx with a FIFO model and a frame-level line receiver.
module tb_fifo_nibble_tx;
  import fifo_tx_pkg::*;

  localparam int unsigned DBITS = 4;
  localparam int unsigned CPB   = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NBITS = bits_per_frame(DBITS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] frames_sent;

  fifo_nibble_tx_if #(.DBITS(DBITS)) fif ();

  fifo_nibble_tx #(
    .DBITS        (DBITS),
    .CLKS_PER_BIT (CPB),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo        (fif),
    .tx          (tx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FIFO model: main flow writes entries, the pop process only advances rd_ptr.
  logic [DBITS-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  int rd_empty_count = 0;
  int exp_rd = 0;
  int exp_frames = 0;

  assign fif.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fif.fifo_rd) begin
      rd_count <= rd_count + 1;
      if (fif.fifo_empty) begin
        rd_empty_count <= rd_empty_count + 1;
      end else begin
        fif.fifo_dout <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DBITS-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  // Waits for a start bit, then checks every cycle of every bit against the frame rules.
  task automatic expect_frame(input logic [DBITS-1:0] d, input int exp_gap, input bit drop_en);
    logic [NBITS-1:0] bits;
    int  gap;
    int  errs;
    int  busy_errs;
    bit  seen;
    gap  = 0;
    seen = 1'b0;
    busy_errs = 0;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < int'(DBITS); i++) bits[1 + i] = d[i];
`ifdef FIFO_TX_PARITY_EN
    bits[DBITS + 1] = ^d;
`endif
    bits[NBITS - 1] = 1'b1;

    while (gap < 2000) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      gap++;
    end
    check_eq("start_seen", 32'(seen), 32'd1);
    if (!seen) return;
    exp_rd++;
    check_eq("idle_gap", 32'(gap), 32'(exp_gap));

    for (int b = 0; b < int'(NBITS); b++) begin
      errs = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (drop_en && b == 2 && c == 1) enable = 1'b0;
        if (tx !== bits[b]) errs++;
        if (busy !== 1'b1) busy_errs++;
      end
      check_eq($sformatf("d%0h_bit%0d", d, b), 32'(errs), 32'd0);
    end
    check_eq("busy_in_frame", 32'(busy_errs), 32'd0);
    exp_frames++;
  endtask

  initial begin
    logic [DBITS-1:0] vals [0:3];
    int n;
    int tx_bad;
    int busy_bad;
    int rd_before;

    // Power-up reset held
    repeat (3) @(negedge clk);
    check_eq("por_tx", 32'(tx), 32'd1);
    check_eq("por_rd", 32'(fif.fifo_rd), 32'd0);
    check_eq("por_busy", 32'(busy), 32'd0);
    check_eq("por_frames", 32'(frames_sent), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Single entry 0xA
    push(4'hA);
    enable = 1'b1;
    expect_frame(4'hA, 2, 1'b0);
    @(negedge clk);
    check_eq("single_busy_fall", 32'(busy), 32'd0);
    check_eq("single_frames", 32'(frames_sent), 32'(exp_frames % 256));
    check_eq("single_rd", 32'(rd_count), 32'(exp_rd));

    // Three back-to-back
    repeat (5) @(negedge clk);
    push(4'h1); push(4'h2); push(4'h3);
    expect_frame(4'h1, 2, 1'b0);
    expect_frame(4'h2, 2, 1'b0);
    expect_frame(4'h3, 2, 1'b0);
    @(negedge clk);
    check_eq("b2b_frames", 32'(frames_sent), 32'(exp_frames % 256));
    check_eq("b2b_rd", 32'(rd_count), 32'(exp_rd));

    // Parity-path entry
    push(4'h7);
    expect_frame(4'h7, 2, 1'b0);

    // Empty FIFO, enabled
    rd_before = rd_count;
    tx_bad = 0;
    busy_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    check_eq("empty_rd", 32'(rd_count), 32'(rd_before));
    check_eq("empty_tx", 32'(tx_bad), 32'd0);
    check_eq("empty_busy", 32'(busy_bad), 32'd0);

    // Enable dropped during frame 1's second data bit
    push(4'h3); push(4'hC);
    expect_frame(4'h3, 2, 1'b1);
    repeat (50) @(negedge clk);
    check_eq("drop_rd", 32'(rd_count), 32'(exp_rd));
    check_eq("drop_frames", 32'(frames_sent), 32'(exp_frames % 256));
    check_eq("drop_busy", 32'(busy), 32'd0);
    check_eq("drop_left", 32'(wr_ptr - rd_ptr), 32'd1);
    enable = 1'b1;
    expect_frame(4'hC, 2, 1'b0);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(20, 0)) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      n = $urandom_range(4, 1);
      for (int i = 0; i < n; i++) begin
        vals[i] = DBITS'($urandom);
        push(vals[i]);
      end
      enable = 1'b1;
      for (int i = 0; i < n; i++) expect_frame(vals[i], 2, 1'b0);
      @(negedge clk);
      check_eq($sformatf("rnd%0d_frames", r), 32'(frames_sent), 32'(exp_frames % 256));
      check_eq($sformatf("rnd%0d_rd", r), 32'(rd_count), 32'(exp_rd));
    end

    // Reset asserted in the middle of DATA
    push(4'h5);
    begin : wait_start
      int w;
      w = 0;
      while (tx !== 1'b0 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      check_eq("rst_start_seen", 32'(tx), 32'd0);
    end
    exp_rd++;
    repeat (CPB + 2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("midrst_tx", 32'(tx), 32'd1);
    check_eq("midrst_rd", 32'(fif.fifo_rd), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_frames", 32'(frames_sent), 32'd0);
    exp_frames = 0;
    repeat (3) @(negedge clk);
    check_eq("midrst_hold_tx", 32'(tx), 32'd1);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("postrst_rd", 32'(rd_count), 32'(exp_rd));
    push(4'h9);
    expect_frame(4'h9, 2, 1'b0);
    @(negedge clk);
    check_eq("postrst_frames", 32'(frames_sent), 32'd1);
    check_eq("postrst_rd2", 32'(rd_count), 32'(exp_rd));

    check_eq("rd_while_empty", 32'(rd_empty_count), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_nibble_tx.md
Name: fifo_nibble_tx

Overview:
Drain side for the on-chip nibble FIFO. When enabled, the block pops one entry at a time through the FIFO's registered-read port and sends it as an asynchronous serial frame on a single pin. Frame format: start bit, data LSB-first, optional parity, stop bit. It sits between the FIFO's dout/empty/read-strobe and a dedicated output pin, and replaces manual push-button reads.

Parameters:
DBITS, 4, data width of one FIFO entry and of each frame's payload
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..255
CNT_W, 8, width of the frames-sent counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
enable  input  1  allow new frames to start; sampled only at frame boundaries
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DBITS  FIFO read data; valid the cycle after fifo_rd and held until the next pop
fifo_rd  output  1  single-cycle pop strobe to the FIFO
tx  output  1  serial line; idle high
busy  output  1  high whenever state is not IDLE
frames_sent  output  CNT_W  count of completed frames; wraps

Behaviour:
- Reset (async, while rst_n=1) forces:
  - tx=1, fifo_rd=0, busy=0, frames_sent=0, state=IDLE
  - baud counter=0, bit index=0, shift register=0
  - Effective immediately, including mid-frame; no partial frame is completed.
- States: IDLE, POP, WAIT, START, DATA, (PARITY), STOP.
- IDLE -> POP at the edge where enable=1 and fifo_empty=0. Otherwise remain in IDLE.
- POP:
  - fifo_rd=1 for exactly this one cycle; it is decoded from the state register, so it is glitch-free.
  - Always -> WAIT.
- WAIT:
  - One cycle; fifo_dout is valid.
  - At the closing edge, fifo_dout is captured into the shift register; -> START.
- START: tx=0 for CLKS_PER_BIT cycles; -> DATA.
- DATA:
  - tx = shift register bit 0, held CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After DBITS bits: -> PARITY if compiled in, else -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the last cycle:
  - frames_sent increments (wraps 2^CNT_W-1 -> 0).
  - If enable=1 and fifo_empty=0 -> POP (back-to-back); else -> IDLE.
- tx is registered; each bit lasts exactly CLKS_PER_BIT cycles with no jitter.
- Latency, condition sampled at edge E0 in IDLE:
  - fifo_rd high E0..E1
  - capture at E2
  - tx falls at E2
- Back-to-back gap: exactly 2 idle-high cycles (POP+WAIT) after the stop bit's last cycle before the next start bit.
- Frame length: (DBITS+2)*CLKS_PER_BIT cycles; +CLKS_PER_BIT with parity. Defaults: 96 cycles, or 112 with parity.
- fifo_rd is never asserted while fifo_empty=1. fifo_empty is ignored in POP/WAIT/START/DATA/PARITY.
- enable deasserted mid-frame: the current frame completes normally; no further pop.
- enable toggling inside a frame has no effect; only its value at the IDLE/STOP decision edge matters.

Optional Feature:
Macro FIFO_TX_PARITY_EN.
- Defined: PARITY state after DATA; tx = even parity (XOR of all DBITS data bits) for CLKS_PER_BIT cycles.
- Undefined: no PARITY state; DATA goes directly to STOP. The state encoding omits PARITY.

Decomposition:
- Package fifo_tx_pkg holds:
  - the state enum typedef
  - the bit-index width constant ($clog2(DBITS+1))
  - the baud counter width constant ($clog2(256))
  - the frame-length constant helpers
- One sub-module, baud_tick_gen:
  - Counter cleared on load, with a bit_done pulse every CLKS_PER_BIT cycles while run=1.
  - Instantiated once.

Test Plan:
- Reset: assert rst_n mid-simulation -> same-cycle tx=1, fifo_rd=0, busy=0, frames_sent=0.
- Single entry 0xA, CLKS_PER_BIT=4, FIFO model holding one word:
  - exactly one fifo_rd pulse
  - tx = 0,0,1,0,1,1, each held 4 cycles
  - frames_sent=1
  - busy falls after 24 cycles of frame
- Three entries 0x1,0x2,0x3 back-to-back, enable=1:
  - three pops
  - 2-cycle idle-high gap between stop end and next start
  - payload bits LSB-first match
  - frames_sent=3
- Empty FIFO, enable=1 for 1000 cycles -> fifo_rd never high, tx=1, busy=0.
- Two entries, enable dropped during the second data bit of frame 1 -> frame 1 completes, no second pop, frames_sent=1.
- Reset asserted during DATA of 0x5 -> tx=1 immediately, counter 0. After release, the next frame starts with a fresh pop.
- With FIFO_TX_PARITY_EN, entry 0x7 -> parity bit 1 after data and before stop.
